// File: rtl/vga_timing_generator.sv
// vga_timing_generator: free-running raster counter with registered row/column, sync and strobe decodes.
// Latency: every output is the decode of the counter value one clock earlier; sync pins add SYNC_DELAY clocks
// when VGA_SYNC_PIPELINE_EN is defined. No backpressure: the raster never stalls, consumers qualify with display_enable.
module vga_timing_generator #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int SYNC_DELAY      = 2
) (
  input  logic        vga_clock,
  input  logic        reset,
  output int          column,
  output int          row,
  output logic        display_enable,
  output logic        h_sync,
  output logic        v_sync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int   H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int   HS_FIRST   = H_VISIBLE + H_FRONT;
  localparam int   HS_LAST    = HS_FIRST + H_SYNC - 1;
  localparam int   VS_FIRST   = V_VISIBLE + V_FRONT;
  localparam int   VS_LAST    = VS_FIRST + V_SYNC - 1;
  localparam logic SYNC_IDLE  = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ACT   = ~SYNC_ACTIVE_LOW;

  int   h;
  int   v;
  logic hs_reg;
  logic vs_reg;

  // Raster counters: h every clock, v when h wraps, both wrap together at the frame end.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      h <= 0;
      v <= 0;
    end else if (h == H_TOTAL - 1) begin
      h <= 0;
      v <= (v == V_TOTAL - 1) ? 0 : v + 1;
    end else begin
      h <= h + 1;
    end
  end

  // Registered decodes of the current counter point; all outputs describe the same (h, v).
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      column         <= 0;
      row            <= 0;
      display_enable <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      hs_reg         <= SYNC_IDLE;
      vs_reg         <= SYNC_IDLE;
    end else begin
      column         <= h;
      row            <= v;
      display_enable <= (h < H_VISIBLE) && (v < V_VISIBLE);
      line_start     <= (h == 0);
      frame_start    <= (h == 0) && (v == 0);
      hs_reg         <= (h >= HS_FIRST && h <= HS_LAST) ? SYNC_ACT : SYNC_IDLE;
      vs_reg         <= (v >= VS_FIRST && v <= VS_LAST) ? SYNC_ACT : SYNC_IDLE;
    end
  end

  // Frame counter steps the clock after frame_start, so frame_start shows the pre-increment value.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (frame_start) begin
      frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VGA_SYNC_PIPELINE_EN
  logic [SYNC_DELAY-1:0] hs_pipe;
  logic [SYNC_DELAY-1:0] vs_pipe;

  // Sync delay line matching the colour pipeline; stages clear to the idle level so no stale pulse survives reset.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      hs_pipe <= {SYNC_DELAY{SYNC_IDLE}};
      vs_pipe <= {SYNC_DELAY{SYNC_IDLE}};
    end else begin
      hs_pipe[0] <= hs_reg;
      vs_pipe[0] <= vs_reg;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign h_sync = hs_pipe[SYNC_DELAY-1];
  assign v_sync = vs_pipe[SYNC_DELAY-1];
`else
  // Sync pins aligned with row/column; the delay setting has no effect in this build.
  logic unused_sync_delay;
  assign unused_sync_delay = (SYNC_DELAY != 0);
  assign h_sync = hs_reg;
  assign v_sync = vs_reg;
`endif

endmodule
